lza_norm_sched: RTL and testbench
=================================

Name: lza_norm_sched

Overview:
- Round-robin scheduler that shares one LZA instance (leading-zero anticipation over C_WIDTH-bit addends) between two requesters, e.g. FMAC add path and a div/sqrt normaliser.
- Arbitrates requests, registers the granted operands, and evaluates the LZA in a 2-stage valid/ready pipeline with backpressure.
- Returns leading-one position, no-one flag, requester ID and tag.

Parameters:
- C_WIDTH, 74, operand width fed to the shared LZA.
- C_LO_WIDTH, C_FMAC_LEADONE_WIDTH (7), width of the leading-one result.
- C_TAG_WIDTH, 4, opaque requester tag carried with each job.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- Flush_SI  in  1  synchronous pipeline flush.
- Req_Valid_SI  in  2  per-requester request valid.
- Req_Ready_SO  out  2  per-requester grant/accept; a transfer occurs when valid&ready.
- Req0_A_DI, Req0_B_DI  in  C_WIDTH each  requester 0 operands.
- Req1_A_DI, Req1_B_DI  in  C_WIDTH each  requester 1 operands.
- Req0_Tag_DI, Req1_Tag_DI  in  C_TAG_WIDTH each  requester tags.
- Res_Valid_SO  out  1  result valid.
- Res_Ready_SI  in  1  result consumer ready.
- Res_Id_SO  out  1  requester index of the result.
- Res_Tag_DO  out  C_TAG_WIDTH  tag of the result.
- Res_LeadOne_DO  out  C_LO_WIDTH  LZA leading-one position.
- Res_NoOne_SO  out  1  LZA no-one flag.
- Busy_SO  out  1  high when either pipeline stage is valid.

Behaviour:
- Reset (Rst_RI=1 at a rising edge): S1/S2 valid=0; Res_Valid_SO=0; Res_Id_SO=0; Res_Tag_DO=0; Res_LeadOne_DO=0; Res_NoOne_SO=0; Busy_SO=0; last-grant pointer=1, so requester 0 wins first. Reset mid-operation drops all in-flight jobs with no output.
- S1 register: A, B, id, tag, valid. The LZA instance is driven combinationally from the S1 A/B registers.
- S2 register: leading-one, no-one, id, tag, valid. The S2 register drives the Res_* outputs directly; no combinational path from Req_* to Res_*.
- Advance rules:
  - s2_accept = !S2.valid | Res_Ready_SI.
  - s1_adv = S1.valid & s2_accept.
  - s1_free = !S1.valid | s1_adv.
- Grant: only when s1_free & !Flush_SI. If one requester is valid, grant it. If both are valid, grant the index != last-grant pointer. The pointer updates only on an actual transfer.
- Req_Ready_SO is asserted only for the granted index. It may depend combinationally on Req_Valid_SI and Res_Ready_SI. A valid request holds until accepted.
- Latency: transfer at edge N → result valid after edge N+1 (2 edges total) when not stalled. Sustained throughput is 1 job/cycle with Res_Ready_SI=1.
- Backpressure: Res_Valid_SO=1 & Res_Ready_SI=0 holds all S2 outputs stable. S1 then fills and holds. Req_Ready_SO=0 once S1 is full and stalled.
- Res_Valid_SO deasserts only after a handshake or on flush/reset.
- Flush_SI=1: clears S1/S2 valid at the next edge. No grant is issued in a flush cycle. The pointer and data registers are unchanged. Flush overrides a simultaneous result handshake; the consumer must treat that result as cancelled.
- Result semantics: Res_LeadOne_DO and Res_NoOne_SO equal exactly the standalone LZA outputs for the granted A/B. No correction is applied here.

Optional Feature:
- Macro LZA_NORM_SCHED_STATS_EN.
- Defined: adds outputs Stat_Jobs_DO [15:0] and Stat_NoOne_DO [15:0]:
  - Stat_Jobs_DO counts result handshakes.
  - Stat_NoOne_DO counts handshakes with Res_NoOne_SO=1.
  - Both counters saturate at 16'hFFFF, are cleared by Rst_RI, and are not cleared by Flush_SI.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: Req_Valid=2'b01, A=B=0, Res_Ready=1 → grant at edge N; Res_Valid=1 after edge N+1 with Id=0, NoOne=1, tag echoed.
- Contention: both valid continuously for 6 cycles, Res_Ready=1 → grant order 0,1,0,1,0,1; results in that order with tags matching the requester sequence.
- Backpressure: 3 jobs from requester 1, Res_Ready=0 for 5 cycles → the first result stays stable; the second job is held in S1; the third job sees Req_Ready=0. On release, all 3 results arrive in order and none is lost or duplicated.
- Random operands: 1000 random A/B pairs from both requesters with random Res_Ready → LeadOne and NoOne match a standalone LZA golden model per job; Id and tag match.
- Flush: 2 jobs in flight, Flush_SI=1 for 1 cycle → Res_Valid=0 and Busy=0 after the edge. The next request is granted per the unchanged pointer.
- Reset mid-stall: reset during a held result → all outputs 0. First grant after reset goes to requester 0 when both request. With LZA_NORM_SCHED_STATS_EN, the counters read 0 after reset, and 70000 handshakes give Stat_Jobs=16'hFFFF.

Source files
------------

// File: rtl/lza_norm_sched.sv
// Round-robin share of one LZA between two requesters (LZA_NORM_SCHED_STATS_EN adds handshake counters).
// Latency: request transfer at edge N, result valid after edge N+1; 1 job/cycle sustained.
// Backpressure: a held result freezes S2, S1 then fills and Req_Ready_SO drops.
module lza_norm_sched #(
   parameter int unsigned C_WIDTH     = 74,
   parameter int unsigned C_LO_WIDTH  = 7,
   parameter int unsigned C_TAG_WIDTH = 4
) (
   input  logic                   Clk_CI,
   input  logic                   Rst_RI,
   input  logic                   Flush_SI,
   input  logic [1:0]             Req_Valid_SI,
   output logic [1:0]             Req_Ready_SO,
   input  logic [C_WIDTH-1:0]     Req0_A_DI,
   input  logic [C_WIDTH-1:0]     Req0_B_DI,
   input  logic [C_WIDTH-1:0]     Req1_A_DI,
   input  logic [C_WIDTH-1:0]     Req1_B_DI,
   input  logic [C_TAG_WIDTH-1:0] Req0_Tag_DI,
   input  logic [C_TAG_WIDTH-1:0] Req1_Tag_DI,
   output logic                   Res_Valid_SO,
   input  logic                   Res_Ready_SI,
   output logic                   Res_Id_SO,
   output logic [C_TAG_WIDTH-1:0] Res_Tag_DO,
   output logic [C_LO_WIDTH-1:0]  Res_LeadOne_DO,
   output logic                   Res_NoOne_SO,
`ifdef LZA_NORM_SCHED_STATS_EN
   output logic [15:0]            Stat_Jobs_DO,
   output logic [15:0]            Stat_NoOne_DO,
`endif
   output logic                   Busy_SO
);

   typedef struct packed {
      logic [C_WIDTH-1:0]     a;
      logic [C_WIDTH-1:0]     b;
      logic                   id;
      logic [C_TAG_WIDTH-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic [C_LO_WIDTH-1:0]  lo;
      logic                   no_one;
      logic                   id;
      logic [C_TAG_WIDTH-1:0] tag;
   } s2_t;

   logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, last_gnt_q, last_gnt_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   logic s2_accept, s1_adv, s1_free, gnt_en, gnt_idx, xfer;
   logic [C_WIDTH-1:0]    lza_t, lza_g, lza_z, t_up, g_dn, z_dn, lza_f;
   logic [C_LO_WIDTH-1:0] lza_lo;
   logic                  lza_no_one;

   // Indicator string: digit i marks a candidate leading one from the T/G/Z pattern at i+1, i, i-1.
   always_comb begin
      lza_t = s1_q.a ^ s1_q.b;
      lza_g = s1_q.a & s1_q.b;
      lza_z = ~(s1_q.a | s1_q.b);
      t_up  = {1'b0, lza_t[C_WIDTH-1:1]};
      g_dn  = {lza_g[C_WIDTH-2:0], 1'b0};
      z_dn  = {lza_z[C_WIDTH-2:0], 1'b1};
      lza_f = ( t_up & ((lza_g & ~z_dn) | (lza_z & ~g_dn)))
            | (~t_up & ((lza_z & ~z_dn) | (lza_g & ~g_dn)));
      lza_no_one = ~|lza_f;
      lza_lo = '0;
      for (int i = 0; i < int'(C_WIDTH); i++) begin
         if (lza_f[i]) lza_lo = C_LO_WIDTH'(int'(C_WIDTH) - 1 - i);
      end
   end

   always_comb begin
      s2_accept = ~s2_vld_q | Res_Ready_SI;
      s1_adv    = s1_vld_q & s2_accept;
      s1_free   = ~s1_vld_q | s1_adv;
      gnt_en    = s1_free & ~Flush_SI;
      if (&Req_Valid_SI) gnt_idx = ~last_gnt_q;
      else               gnt_idx = Req_Valid_SI[1];
      xfer = gnt_en & Req_Valid_SI[gnt_idx];
      Req_Ready_SO          = '0;
      Req_Ready_SO[gnt_idx] = xfer;

      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (Flush_SI) begin
         s1_vld_d = 1'b0;
      end else if (xfer) begin
         s1_vld_d = 1'b1;
         s1_d.a   = gnt_idx ? Req1_A_DI   : Req0_A_DI;
         s1_d.b   = gnt_idx ? Req1_B_DI   : Req0_B_DI;
         s1_d.tag = gnt_idx ? Req1_Tag_DI : Req0_Tag_DI;
         s1_d.id  = gnt_idx;
      end else if (s1_adv) begin
         s1_vld_d = 1'b0;
      end

      s2_vld_d = s2_vld_q;
      s2_d     = s2_q;
      if (Flush_SI) begin
         s2_vld_d = 1'b0;
      end else if (s2_accept) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) s2_d = '{lo: lza_lo, no_one: lza_no_one, id: s1_q.id, tag: s1_q.tag};
      end

      last_gnt_d = xfer ? gnt_idx : last_gnt_q;
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         last_gnt_q <= 1'b1;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s2_vld_q   <= s2_vld_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   assign Res_Valid_SO   = s2_vld_q;
   assign Res_Id_SO      = s2_q.id;
   assign Res_Tag_DO     = s2_q.tag;
   assign Res_LeadOne_DO = s2_q.lo;
   assign Res_NoOne_SO   = s2_q.no_one;
   assign Busy_SO        = s1_vld_q | s2_vld_q;

`ifdef LZA_NORM_SCHED_STATS_EN
   logic [15:0] jobs_q, jobs_d, noone_q, noone_d;
   logic        res_hs;

   // A result handshaken during a flush is cancelled, so it is not counted.
   always_comb begin
      res_hs  = s2_vld_q & Res_Ready_SI & ~Flush_SI;
      jobs_d  = jobs_q;
      noone_d = noone_q;
      if (res_hs && jobs_q != 16'hFFFF) jobs_d = jobs_q + 16'd1;
      if (res_hs && s2_q.no_one && noone_q != 16'hFFFF) noone_d = noone_q + 16'd1;
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         jobs_q  <= '0;
         noone_q <= '0;
      end else begin
         jobs_q  <= jobs_d;
         noone_q <= noone_d;
      end
   end

   assign Stat_Jobs_DO  = jobs_q;
   assign Stat_NoOne_DO = noone_q;
`endif

endmodule

// File: tb/tb_lza_norm_sched.sv
// Randomized bench for lza_norm_sched against a job-queue reference model and a digit-pattern LZA model.
module tb_lza_norm_sched;
   localparam int W  = 74;
   localparam int LW = 7;
   localparam int TW = 4;

   typedef struct {
      bit          id;
      bit [TW-1:0] tag;
      bit [LW-1:0] lo;
      bit          no;
      bit          at_out;
   } job_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, res_rdy;
   logic [1:0]    pend, req_rdy;
   logic [W-1:0]  ra [2];
   logic [W-1:0]  rb [2];
   logic [TW-1:0] rt [2];
   logic          res_vld, res_id, res_no, busy;
   logic [TW-1:0] res_tag;
   logic [LW-1:0] res_lo;
`ifdef LZA_NORM_SCHED_STATS_EN
   logic [15:0]   stat_jobs, stat_noone;
   int            m_jobs, m_noone;
`endif

   job_t pipe[$];
   int   seen_ids[$];
   bit   ptr;
   int   n_chk, n_err, issued;
   int   given [2];

   lza_norm_sched #(.C_WIDTH(W), .C_LO_WIDTH(LW), .C_TAG_WIDTH(TW)) dut (
      .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush),
      .Req_Valid_SI(pend), .Req_Ready_SO(req_rdy),
      .Req0_A_DI(ra[0]), .Req0_B_DI(rb[0]), .Req1_A_DI(ra[1]), .Req1_B_DI(rb[1]),
      .Req0_Tag_DI(rt[0]), .Req1_Tag_DI(rt[1]),
      .Res_Valid_SO(res_vld), .Res_Ready_SI(res_rdy), .Res_Id_SO(res_id),
      .Res_Tag_DO(res_tag), .Res_LeadOne_DO(res_lo), .Res_NoOne_SO(res_no),
`ifdef LZA_NORM_SCHED_STATS_EN
      .Stat_Jobs_DO(stat_jobs), .Stat_NoOne_DO(stat_noone),
`endif
      .Busy_SO(busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Digit class of the addend pair at position i: 0 zero, 1 transfer, 2 generate; outside the word is zero.
   function automatic int cls(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
      if (i < 0 || i >= W) return 0;
      if (a[i] & b[i]) return 2;
      if (a[i] | b[i]) return 1;
      return 0;
   endfunction

   function automatic void lza_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output bit [LW-1:0] lo, output bit no);
      int up, cur, dn;
      bit hit;
      no = 1'b1;
      lo = '0;
      for (int i = W - 1; i >= 0; i--) begin
         up  = cls(a, b, i + 1);
         cur = cls(a, b, i);
         dn  = cls(a, b, i - 1);
         if (up == 1) hit = (cur == 2 && dn != 0) || (cur == 0 && dn != 2);
         else         hit = (cur == 0 && dn != 0) || (cur == 2 && dn != 2);
         if (hit && no) begin
            no = 1'b0;
            lo = LW'(W - 1 - i);
         end
      end
   endfunction

   task automatic req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
      ra[i] = a;
      rb[i] = b;
      rt[i] = t;
      pend[i] = 1'b1;
   endtask

   function automatic logic [W-1:0] rnd_w();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return W'(r >> $urandom_range(0, 96));
   endfunction

   task automatic req_rand(input int i);
      logic [W-1:0] a, b;
      a = rnd_w();
      case ($urandom_range(0, 3))
         0: b = rnd_w();
         1: b = ~a;
         2: b = ~a + W'(1);
         default: b = a;
      endcase
      req(i, a, b, TW'($urandom()));
   endtask

   // One cycle: compare at the falling edge, advance the model, then step past the rising edge.
   task automatic step();
      bit out_v, s1_occ, adv;
      logic [1:0] exp_rdy;
      int gi;
      job_t j;
      @(negedge clk);
      out_v  = pipe.size() > 0 && pipe[0].at_out;
      s1_occ = pipe.size() == 2 || (pipe.size() == 1 && !pipe[0].at_out);
      adv    = !out_v || res_rdy;
      exp_rdy = '0;
      gi = 0;
      if (!flush && !(s1_occ && !adv) && pend != 2'b00) begin
         gi = (pend == 2'b11) ? int'(!ptr) : (pend[1] ? 1 : 0);
         exp_rdy[gi] = 1'b1;
      end
      chk("req_rdy", req_rdy, exp_rdy);
      chk("res_vld", res_vld, out_v);
      chk("busy", busy, pipe.size() != 0);
      if (out_v) begin
         chk("res_id", res_id, pipe[0].id);
         chk("res_tag", res_tag, pipe[0].tag);
         chk("res_lo", res_lo, pipe[0].lo);
         chk("res_no", res_no, pipe[0].no);
      end
      if (res_vld && res_rdy && !flush && !rst) seen_ids.push_back(int'(res_id));
      if (rst) begin
         pipe.delete();
         ptr = 1'b1;
         exp_rdy = '0;
`ifdef LZA_NORM_SCHED_STATS_EN
         m_jobs = 0;
         m_noone = 0;
`endif
      end else if (flush) begin
         pipe.delete();
      end else begin
         if (out_v && res_rdy) begin
`ifdef LZA_NORM_SCHED_STATS_EN
            if (m_jobs < 65535) m_jobs++;
            if (pipe[0].no && m_noone < 65535) m_noone++;
`endif
            void'(pipe.pop_front());
         end
         if (adv) foreach (pipe[k]) pipe[k].at_out = 1'b1;
         if (exp_rdy != 2'b00) begin
            j.id = gi[0];
            j.tag = rt[gi];
            lza_ref(ra[gi], rb[gi], j.lo, j.no);
            j.at_out = 1'b0;
            pipe.push_back(j);
            ptr = gi[0];
            issued++;
         end
      end
      @(posedge clk);
      #1;
      pend = pend & ~exp_rdy;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pipe.size() != 0 || pend != 2'b00) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("drain_timeout", {busy, pend}, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vld"}, res_vld, 0);
      chk({tag, "_id"}, res_id, 0);
      chk({tag, "_tag"}, res_tag, 0);
      chk({tag, "_lo"}, res_lo, 0);
      chk({tag, "_no"}, res_no, 0);
      chk({tag, "_busy"}, busy, 0);
`ifdef LZA_NORM_SCHED_STATS_EN
      chk({tag, "_sjobs"}, stat_jobs, 0);
      chk({tag, "_snoone"}, stat_noone, 0);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, guard;
      bit saved_ptr;
      logic [TW-1:0] held_tag;
      rst = 1'b1; flush = 1'b0; res_rdy = 1'b1; pend = '0; ptr = 1'b1;
      for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rt[i] = '0; end
`ifdef LZA_NORM_SCHED_STATS_EN
      m_jobs = 0; m_noone = 0;
`endif
      step(); step();
      rst = 1'b0;
      chk_zero("reset");

      // Single request, zero operands
      req(0, '0, '0, 4'h5);
      step(); step();
      chk("single_vld", res_vld, 1);
      chk("single_id", res_id, 0);
      chk("single_no", res_no, 1);
      chk("single_tag", res_tag, 4'h5);
      drain(20);

      // Contention from a fresh pointer
      rst = 1'b1; step(); rst = 1'b0;
      seen_ids.delete();
      given[0] = 0; given[1] = 0; guard = 0;
      while ((given[0] < 3 || given[1] < 3 || pend != 2'b00) && guard < 40) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && given[i] < 3) begin
               req(i, rnd_w(), rnd_w(), TW'(i * 8 + given[i]));
               given[i]++;
            end
         step();
         guard++;
      end
      drain(20);
      chk("cont_count", seen_ids.size(), 6);
      for (int k = 0; k < 6 && k < seen_ids.size(); k++) chk("cont_order", seen_ids[k], k % 2);

      // Backpressure: three jobs from requester 1 against a stalled consumer
      seen_ids.delete();
      res_rdy = 1'b0;
      given[1] = 0;
      held_tag = 4'hA;
      for (int c = 0; c < 5; c++) begin
         if (!pend[1] && given[1] < 3) begin
            req(1, rnd_w(), rnd_w(), TW'(4'hA + given[1]));
            given[1]++;
         end
         step();
      end
      chk("bp_rdy", req_rdy, 2'b00);
      chk("bp_held_tag", res_tag, held_tag);
      chk("bp_vld", res_vld, 1);
      res_rdy = 1'b1;
      drain(20);
      chk("bp_count", seen_ids.size(), 3);
      for (int k = 0; k < seen_ids.size(); k++) chk("bp_id", seen_ids[k], 1);

      // Random operands and random consumer readiness
      base = issued; guard = 0;
      while (issued - base < 1000 && guard < 20000) begin
         res_rdy = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 9) < 6) req_rand(i);
         step();
         guard++;
      end
      if (guard >= 20000) chk("rand_timeout", {busy, pend}, 0);
      res_rdy = 1'b1;
      drain(50);

      // Flush with two jobs in flight
      res_rdy = 1'b0;
      req_rand(0);
      req_rand(1);
      step(); step();
      chk("flush_pre_busy", busy, 1);
      saved_ptr = ptr;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_vld", res_vld, 0);
      chk("flush_busy", busy, 0);
      req_rand(0);
      req_rand(1);
      #1;
      chk("flush_ptr", req_rdy, saved_ptr ? 2'b01 : 2'b10);
      res_rdy = 1'b1;
      drain(20);

      // Reset while a result is held
      res_rdy = 1'b0;
      req_rand(1);
      step(); step(); step();
      chk("stall_vld", res_vld, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero("mid_rst");
      req_rand(0);
      req_rand(1);
      #1;
      chk("rst_first", req_rdy, 2'b01);
      res_rdy = 1'b1;
      drain(20);

`ifdef LZA_NORM_SCHED_STATS_EN
      for (int k = 0; k < 70010; k++) begin
         if (!pend[0]) req(0, '0, '0, '0);
         step();
      end
      drain(20);
      chk("stat_jobs", stat_jobs, m_jobs);
      chk("stat_noone", stat_noone, m_noone);
      chk("stat_jobs_sat", stat_jobs, 16'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
